// File: rtl/nv_clk_gate_ctrl_if.sv
// Requester-side handshake bundle for the clock-gate controller.
// The requesters drive busy/wake; the controller returns per-requester grants.
interface nv_clk_gate_ctrl_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req_busy;
    logic [NREQ-1:0] wake_req;
    logic [NREQ-1:0] wake_ack;

    modport master (output req_busy, output wake_req, input wake_ack);
    modport slave  (input req_busy, input wake_req, output wake_ack);
endinterface

// File: rtl/nv_clk_gate_ctrl.sv
// Idle-driven clock-gate controller: gates one clock domain after a programmable
// quiet period and re-enables it with a fixed settle delay before granting wakes.
module nv_clk_gate_ctrl #(
    parameter int NREQ     = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_cg_disable,
    input  logic [IDLE_W-1:0]    cfg_idle_thresh,
    nv_clk_gate_ctrl_if.slave    bus,
    output logic                 clk_en,
    output logic [1:0]           cg_state,
    output logic [15:0]          cg_gated_cnt
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic [3:0]        r_wake_cnt;
    logic [3:0]        w_wake_nxt;
    logic [15:0]       r_gated_cnt;
    logic              w_act;
    logic              w_gate_entry;

    assign w_act = (|bus.req_busy) | (|bus.wake_req) | cfg_cg_disable;

    always_comb begin
        w_state_nxt  = r_state;
        w_idle_nxt   = r_idle_cnt;
        w_wake_nxt   = r_wake_cnt;
        w_gate_entry = 1'b0;
        case (r_state)
            RUN: begin
                if (!w_act) begin
                    w_state_nxt = IDLE_WAIT;
                    w_idle_nxt  = '0;
                end
            end
            IDLE_WAIT: begin
                // Activity wins over an expiring threshold.
                if (w_act) begin
                    w_state_nxt = RUN;
                    w_idle_nxt  = '0;
                end else if (r_idle_cnt >= cfg_idle_thresh) begin
                    w_state_nxt  = GATED;
                    w_gate_entry = 1'b1;
                end else begin
                    w_idle_nxt = r_idle_cnt + 1'b1;
                end
            end
            GATED: begin
                if (w_act) begin
                    w_state_nxt = WAKE;
                    w_wake_nxt  = 4'(WAKE_CYC - 1);
                end
            end
            WAKE: begin
                // Settle runs to completion even if the request has gone away.
                if (r_wake_cnt == 4'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_wake_nxt = r_wake_cnt - 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            r_gated_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_wake_cnt <= w_wake_nxt;
            if (w_gate_entry && (r_gated_cnt != 16'hFFFF)) begin
                r_gated_cnt <= r_gated_cnt + 16'd1;
            end
        end
    end

    // Enable comes from the state register alone so the gate cell never sees input glitches.
    assign clk_en       = (r_state != GATED);
    assign cg_state     = r_state;
    assign cg_gated_cnt = r_gated_cnt;
    assign bus.wake_ack = bus.wake_req & {NREQ{(r_state == RUN) && !reset}};
endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Bench for nv_clk_gate_ctrl: directed scenarios followed by a random phase,
// every cycle compared against an event-level reference model.
module tb_nv_clk_gate_ctrl;
    localparam int NREQ     = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;

    logic              clk;
    logic              reset;
    logic              dis;
    logic [IDLE_W-1:0] thr;
    logic              clk_en;
    logic [1:0]        cg_state;
    logic [15:0]       cg_gated_cnt;

    nv_clk_gate_ctrl_if #(.NREQ(NREQ)) bus ();

    nv_clk_gate_ctrl #(.NREQ(NREQ), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_cg_disable (dis),
        .cfg_idle_thresh(thr),
        .bus            (bus),
        .clk_en         (clk_en),
        .cg_state       (cg_state),
        .cg_gated_cnt   (cg_gated_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode 0 running, 1 counting quiet cycles, 2 clock off, 3 settling.
    int m_mode  = 0;
    int m_quiet = 0;
    int m_settle_elapsed = 0;
    int m_entries = 0;
    bit m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit activity();
        return (bus.req_busy != 0) || (bus.wake_req != 0) || dis;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_quiet = 0; m_settle_elapsed = 0; m_entries = 0; m_known = 1'b1;
        end else if (m_known) begin
            case (m_mode)
                0: if (!activity()) begin m_mode = 1; m_quiet = 0; end
                1: begin
                    if (activity()) begin
                        m_mode = 0; m_quiet = 0;
                    end else if (m_quiet >= int'(thr)) begin
                        m_mode = 2;
                        m_entries = (m_entries < 65535) ? m_entries + 1 : 65535;
                    end else begin
                        m_quiet++;
                    end
                end
                2: if (activity()) begin m_mode = 3; m_settle_elapsed = 1; end
                default: begin
                    if (m_settle_elapsed >= WAKE_CYC) m_mode = 0;
                    else m_settle_elapsed++;
                end
            endcase
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [NREQ-1:0] exp_ack;
        #1;
        exp_ack = (m_known && !reset && m_mode == 0) ? bus.wake_req : '0;
        chk("wake_ack", bus.wake_ack, exp_ack);
        if (m_known) begin
            chk("cg_state", cg_state, m_mode);
            chk("clk_en", clk_en, (m_mode != 2));
            chk("gated_cnt", cg_gated_cnt, m_entries);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_to_gated(input int bound);
        int n;
        n = 0;
        while (cg_state != 2'd2 && n < bound) begin
            tick();
            n++;
        end
        chk("reach_gated", cg_state, 2'd2);
    endtask

    initial begin
        logic [1:0] seq [7];
        int first;
        logic [15:0] cnt0;
        seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

        // Reset with requests high: grants must stay low throughout.
        reset = 1'b1; dis = 1'b0; thr = 8'd4;
        bus.req_busy = '0; bus.wake_req = 4'hF;
        tick(); tick();
        bus.wake_req = '0;
        reset = 1'b0;

        // Quiet after reset, thresh 4: RUN then five IDLE_WAIT cycles then GATED.
        for (int i = 0; i < 7; i++) begin
            chk("s1_seq", cg_state, seq[i]);
            tick();
        end
        chk("s1_clken_off", clk_en, 1'b0);
        chk("s1_cnt", cg_gated_cnt, 16'd1);

        // Wake from GATED on requester 2, held until granted.
        bus.wake_req = 4'b0100;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 1) chk("s2_clken_next", clk_en, 1'b1);
            if (bus.wake_ack[2]) begin
                first = i;
                break;
            end
            tick();
        end
        chk("s2_ack_latency", first, 1 + WAKE_CYC);
        chk("s2_other_acks", bus.wake_ack & 4'b1011, 4'b0000);
        tick();
        bus.wake_req = '0;

        // Busy arriving exactly when the idle count meets the threshold.
        thr = 8'd2;
        tick(); tick(); tick();
        chk("s3_idle_at_thr", dut.r_idle_cnt, m_quiet);
        cnt0 = cg_gated_cnt;
        bus.req_busy = 4'b0001;
        tick();
        chk("s3_back_to_run", cg_state, 2'd0);
        chk("s3_cnt_same", cg_gated_cnt, cnt0);
        bus.req_busy = '0;

        // Disable while gated: wakes, then holds the clock on.
        thr = 8'd1;
        run_to_gated(20);
        dis = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("s4_run_held", cg_state, 2'd0);
        chk("s4_clken_held", clk_en, 1'b1);
        dis = 1'b0; thr = 8'd0;
        tick(); tick();
        chk("s4_gated_2cyc", cg_state, 2'd2);

        // Saturation: preload near the top, then three more gating entries.
        force dut.r_gated_cnt = 16'hFFFD;
        m_entries = 16'hFFFD;
        tick();
        release dut.r_gated_cnt;
        for (int k = 0; k < 3; k++) begin
            bus.wake_req = 4'b1000;
            tick();
            bus.wake_req = '0;
            run_to_gated(20);
        end
        chk("s5_saturated", cg_gated_cnt, 16'hFFFF);

        // Reset in the middle of the settle period.
        bus.wake_req = 4'b0010;
        tick();
        bus.wake_req = '0;
        tick();
        chk("s6_in_wake", cg_state, 2'd3);
        reset = 1'b1; bus.wake_req = 4'hF;
        tick();
        #1;
        chk("s6_state", cg_state, 2'd0);
        chk("s6_clken", clk_en, 1'b1);
        chk("s6_ack", bus.wake_ack, 4'h0);
        chk("s6_idle_cnt", dut.r_idle_cnt, 0);
        chk("s6_wake_cnt", dut.r_wake_cnt, 0);
        chk("s6_gated_cnt", cg_gated_cnt, 0);
        reset = 1'b0; bus.wake_req = '0;
        tick();

        // Random traffic with occasional threshold changes, disables and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) thr = 8'($urandom_range(0, 6));
            bus.req_busy = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            bus.wake_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            dis   = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
